// File: rtl/count_display_driver.sv
// Converts the counter value to BCD with a free-running 10-cycle double-dabble
// engine and scans it onto a 3-digit multiplexed 7-segment display.
module count_display_driver #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value_in,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_units,
  output logic       bcd_valid,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_LOAD
  } convState_t;

  convState_t r_state;
  logic [7:0]  r_shift;
  logic [11:0] r_scratch;
  logic [2:0]  r_bitCnt;
  logic [3:0]  r_bcdHund;
  logic [3:0]  r_bcdTens;
  logic [3:0]  r_bcdUnits;
  logic        r_bcdValid;

  logic [CNT_W-1:0] r_refreshCnt;
  logic [1:0]       r_digitSel;
  logic [6:0]       r_seg;
  logic [2:0]       r_an;

  logic [11:0] w_adjusted;
  logic [19:0] w_shifted;
  logic [3:0]  w_digit;
  logic        w_blank;
  logic [6:0]  w_segRaw;
  logic [2:0]  w_anRaw;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [6:0] segDecode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // One double-dabble step: correct each nibble, then shift scratch:shift left.
  assign w_adjusted = {add3(r_scratch[11:8]), add3(r_scratch[7:4]), add3(r_scratch[3:0])};
  assign w_shifted  = {w_adjusted[10:0], r_shift, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_scratch  <= '0;
      r_bitCnt   <= '0;
      r_bcdHund  <= '0;
      r_bcdTens  <= '0;
      r_bcdUnits <= '0;
      r_bcdValid <= 1'b0;
    end else begin
      r_bcdValid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_shift   <= value_in;
          r_scratch <= '0;
          r_bitCnt  <= '0;
          r_state   <= S_CONV;
        end
        S_CONV: begin
          r_scratch <= w_shifted[19:8];
          r_shift   <= w_shifted[7:0];
          r_bitCnt  <= r_bitCnt + 3'd1;
          if (r_bitCnt == 3'd7) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_bcdHund  <= r_scratch[11:8];
          r_bcdTens  <= r_scratch[7:4];
          r_bcdUnits <= r_scratch[3:0];
          r_bcdValid <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_refreshCnt <= '0;
      r_digitSel   <= 2'd0;
    end else if (r_refreshCnt == CNT_MAX) begin
      r_refreshCnt <= '0;
      r_digitSel   <= (r_digitSel == 2'd2) ? 2'd0 : r_digitSel + 2'd1;
    end else begin
      r_refreshCnt <= r_refreshCnt + CNT_W'(1);
    end
  end

  // Leading-zero blanking: units always lit so a value of 0 still shows "0".
  always_comb begin
    w_digit = r_bcdUnits;
    w_blank = 1'b0;
    w_anRaw = 3'b001;
    case (r_digitSel)
      2'd1: begin
        w_digit = r_bcdTens;
        w_blank = (r_bcdHund == 4'd0) && (r_bcdTens == 4'd0);
        w_anRaw = 3'b010;
      end
      2'd2: begin
        w_digit = r_bcdHund;
        w_blank = (r_bcdHund == 4'd0);
        w_anRaw = 3'b100;
      end
      default: ;
    endcase
    w_segRaw = w_blank ? 7'h00 : segDecode(w_digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= SEG_ACTIVE_LOW ? ~7'h3F : 7'h3F;
      r_an  <= AN_ACTIVE_LOW ? 3'b110 : 3'b001;
    end else begin
      r_seg <= SEG_ACTIVE_LOW ? ~w_segRaw : w_segRaw;
      r_an  <= AN_ACTIVE_LOW ? ~w_anRaw : w_anRaw;
    end
  end

  assign bcd_hund  = r_bcdHund;
  assign bcd_tens  = r_bcdTens;
  assign bcd_units = r_bcdUnits;
  assign bcd_valid = r_bcdValid;
  assign seg       = r_seg;
  assign an        = r_an;

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench for count_display_driver (REFRESH_DIV=4, active-low outputs).
module tb_count_display_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] value_in;
  logic [3:0] bcd_hund, bcd_tens, bcd_units;
  logic       bcd_valid;
  logic [6:0] seg;
  logic [2:0] an;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [7:0] value;
    logic [3:0] h, t, u;
    logic [6:0] segH, segT, segU;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] hist[$];

  always #5 clk = ~clk;

  count_display_driver #(
    .REFRESH_DIV(4),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .value_in(value_in),
    .bcd_hund(bcd_hund),
    .bcd_tens(bcd_tens),
    .bcd_units(bcd_units),
    .bcd_valid(bcd_valid),
    .seg(seg),
    .an(an)
  );

  // Reference: decimal digits by plain arithmetic, packed as three nibbles.
  function automatic int modelBcd(input int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic logic [2:0] nextAn(input logic [2:0] a);
    case (a)
      3'b110:  return 3'b101;
      3'b101:  return 3'b011;
      default: return 3'b110;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkBcd(input string name, input int expected);
    checkOutput(name, {20'd0, bcd_hund, bcd_tens, bcd_units}, expected);
  endtask

  task automatic waitValid(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bcd_valid && n < budget);
    checkOutput("valid_seen", int'(bcd_valid), 1);
  endtask

  task automatic applyStimulus(input logic [7:0] v);
    int n;
    value_in = v;
    waitValid(25, n);
    waitValid(25, n);
  endtask

  // Watches several scan rotations: legal anode, segment per slot, order and dwell.
  task automatic checkScan(input logic [6:0] sh, input logic [6:0] st, input logic [6:0] su);
    logic [2:0] prevAn;
    logic [6:0] expSeg;
    int run;
    bit firstRun;
    bit legal;
    prevAn = 3'b000;
    run = 0;
    firstRun = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      legal = 1'b1;
      expSeg = su;
      case (an)
        3'b110:  expSeg = su;
        3'b101:  expSeg = st;
        3'b011:  expSeg = sh;
        default: legal = 1'b0;
      endcase
      checkOutput("an_onehot", int'(legal), 1);
      if (legal) checkOutput("scan_seg", int'(seg), int'(expSeg));
      if (c == 0) begin
        prevAn = an;
        run = 1;
      end else if (an == prevAn) begin
        run++;
      end else begin
        checkOutput("an_order", int'(an), int'(nextAn(prevAn)));
        if (!firstRun) checkOutput("an_dwell", run, 4);
        firstRun = 1'b0;
        run = 1;
        prevAn = an;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int k;
    bit found;

    vecs[0] = '{8'd255, 4'd2, 4'd5, 4'd5, 7'h24, 7'h12, 7'h12};
    vecs[1] = '{8'd7,   4'd0, 4'd0, 4'd7, 7'h7F, 7'h7F, 7'h78};
    vecs[2] = '{8'd0,   4'd0, 4'd0, 4'd0, 7'h7F, 7'h7F, 7'h40};
    vecs[3] = '{8'd100, 4'd1, 4'd0, 4'd0, 7'h79, 7'h40, 7'h40};
    vecs[4] = '{8'd10,  4'd0, 4'd1, 4'd0, 7'h7F, 7'h79, 7'h40};
    vecs[5] = '{8'd9,   4'd0, 4'd0, 4'd9, 7'h7F, 7'h7F, 7'h10};
    vecs[6] = '{8'd199, 4'd1, 4'd9, 4'd9, 7'h79, 7'h10, 7'h10};
    vecs[7] = '{8'd250, 4'd2, 4'd5, 4'd0, 7'h24, 7'h12, 7'h40};

    rst = 1'b1;
    value_in = 8'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset_an", int'(an), 3'b110);
    checkOutput("reset_seg", int'(seg), 7'h40);
    checkBcd("reset_bcd", 0);
    checkOutput("reset_valid", int'(bcd_valid), 0);
    rst = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].value);
      checkOutput("vec_hund", int'(bcd_hund), int'(vecs[i].h));
      checkOutput("vec_tens", int'(bcd_tens), int'(vecs[i].t));
      checkOutput("vec_units", int'(bcd_units), int'(vecs[i].u));
      checkScan(vecs[i].segH, vecs[i].segT, vecs[i].segU);
    end

    $display("[TB] change during conversion");
    waitValid(25, n);
    value_in = 8'd100;
    k = 0;
    repeat (3) begin
      @(negedge clk);
      k++;
    end
    value_in = 8'd101;
    do begin
      @(negedge clk);
      k++;
    end while (!bcd_valid && k < 25);
    checkOutput("latency_first", k, 10);
    checkBcd("midconv_first", modelBcd(100));
    waitValid(25, n);
    checkOutput("latency_second", n, 10);
    checkBcd("midconv_second", modelBcd(101));

    $display("[TB] wrap 0 -> 255");
    applyStimulus(8'd0);
    repeat ($urandom_range(0, 9)) @(negedge clk);
    value_in = 8'd255;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if ({bcd_hund, bcd_tens, bcd_units} == 12'h255) found = 1'b1;
    end
    checkOutput("wrap_lag", int'(found), 1);

    $display("[TB] full sweep");
    waitValid(25, n);
    for (int v = 0; v < 256; v++) begin
      value_in = 8'(v);
      repeat (10) @(negedge clk);
      checkOutput("sweep_valid", int'(bcd_valid), 1);
      checkBcd("sweep_bcd", modelBcd(v));
    end

    $display("[TB] random scoreboard");
    waitValid(25, n);
    hist.delete();
    value_in = 8'($urandom_range(0, 255));
    hist.push_back(value_in);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      checkOutput("rand_valid", int'(bcd_valid), (c % 10 == 0) ? 1 : 0);
      if (bcd_valid && c >= 10) checkBcd("rand_bcd", modelBcd(int'(hist[c - 10])));
      if ($urandom_range(0, 3) == 0) value_in = 8'($urandom_range(0, 255));
      hist.push_back(value_in);
    end

    $display("[TB] reset mid-conversion");
    waitValid(25, n);
    value_in = 8'd123;
    waitValid(25, n);
    checkBcd("pre_reset_bcd", modelBcd(123));
    value_in = 8'd45;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkBcd("midreset_bcd", 0);
    checkOutput("midreset_valid", int'(bcd_valid), 0);
    checkOutput("midreset_an", int'(an), 3'b110);
    checkOutput("midreset_seg", int'(seg), 7'h40);
    rst = 1'b0;
    waitValid(25, n);
    checkOutput("post_reset_latency", n, 10);
    checkBcd("post_reset_bcd", modelBcd(45));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
